idu_is_iq: RTL

Parametrised out-of-order issue queue for the IDU issue stage. It holds up to DEPTH renamed instructions and wakes their source operands from WAKE_N broadcast ports. Each cycle it issues the oldest fully-ready entry to one execution pipe. It replaces a bank of hand-instantiated single-entry slots: allocation, age ordering, select and free-list management are all internal to the block.

---
 rtl/idu_is_iq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/idu_is_iq.sv
// idu_is_iq: out-of-order issue queue for the IDU issue stage.
// Holds up to DEPTH renamed instructions, wakes source operands from WAKE_N
// broadcast ports and issues the oldest fully-ready entry each cycle.
// Optional build macro: IDU_IS_IQ_FULL_BYPASS_EN lets a create be accepted
// while full in the same cycle as an issue, reusing the slot being freed.
module idu_is_iq #(
  parameter int DEPTH  = 8,
  parameter int WAKE_N = 10,
  parameter int PREG_W = 6,
  parameter int PLD_W  = 152,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_clk,
  input  logic                     rtu_global_flush,
  input  logic                     create_vld,
  output logic                     create_rdy,
  input  logic                     create_psrc1_vld,
  input  logic                     create_psrc2_vld,
  input  logic                     create_psrc1_ready,
  input  logic                     create_psrc2_ready,
  input  logic [PREG_W-1:0]        create_psrc1,
  input  logic [PREG_W-1:0]        create_psrc2,
  input  logic                     create_pdst_vld,
  input  logic [PREG_W-1:0]        create_pdst,
  input  logic [PLD_W-1:0]         create_payload,
  input  logic [WAKE_N-1:0]        wake_vld,
  input  logic [WAKE_N*PREG_W-1:0] wake_preg,
  output logic                     issue_vld,
  input  logic                     issue_rdy,
  output logic [PREG_W-1:0]        issue_psrc1,
  output logic [PREG_W-1:0]        issue_psrc2,
  output logic [PREG_W-1:0]        issue_pdst,
  output logic                     issue_psrc1_vld,
  output logic                     issue_psrc2_vld,
  output logic                     issue_pdst_vld,
  output logic [PLD_W-1:0]         issue_payload,
  output logic [CNT_W-1:0]         entry_cnt
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  ent_vld, s1_vld, s1_rdy, s2_vld, s2_rdy, pd_vld;
  logic [PREG_W-1:0] s1_tag [DEPTH];
  logic [PREG_W-1:0] s2_tag [DEPTH];
  logic [PREG_W-1:0] pd_tag [DEPTH];
  logic [PLD_W-1:0]  pld    [DEPTH];
  // older[i][j] = 1 means entry i is older than entry j
  logic [DEPTH-1:0]  older  [DEPTH];
  logic [CNT_W-1:0]  cnt;

  logic [DEPTH-1:0] ent_rdy, blk_vec, sel_oh, alloc_oh, w1_hit, w2_hit;
  logic             cr1_hit, cr2_hit, alloc_found, iss_fire, cr_fire;

  // Tag compare of every broadcast port against stored and incoming sources
  always_comb begin
    w1_hit  = '0;
    w2_hit  = '0;
    cr1_hit = 1'b0;
    cr2_hit = 1'b0;
    for (int k = 0; k < WAKE_N; k++) begin
      if (wake_vld[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (s1_tag[i] == wake_preg[k*PREG_W +: PREG_W]) w1_hit[i] = 1'b1;
          if (s2_tag[i] == wake_preg[k*PREG_W +: PREG_W]) w2_hit[i] = 1'b1;
        end
        if (create_psrc1 == wake_preg[k*PREG_W +: PREG_W]) cr1_hit = 1'b1;
        if (create_psrc2 == wake_preg[k*PREG_W +: PREG_W]) cr2_hit = 1'b1;
      end
    end
  end

  // Oldest-ready select: an entry wins if no other ready entry is older
  always_comb begin
    ent_rdy = ent_vld & (s1_rdy | ~s1_vld) & (s2_rdy | ~s2_vld);
    blk_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ent_rdy[j] && older[j][i]) blk_vec[i] = 1'b1;
      end
    end
    sel_oh = ent_rdy & ~blk_vec;
  end

  // Issue output mux; sel_oh is one-hot so an OR-mux is sufficient
  always_comb begin
    issue_vld       = |ent_rdy;
    issue_psrc1     = '0;
    issue_psrc2     = '0;
    issue_pdst      = '0;
    issue_psrc1_vld = 1'b0;
    issue_psrc2_vld = 1'b0;
    issue_pdst_vld  = 1'b0;
    issue_payload   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        issue_psrc1     = issue_psrc1 | s1_tag[i];
        issue_psrc2     = issue_psrc2 | s2_tag[i];
        issue_pdst      = issue_pdst | pd_tag[i];
        issue_psrc1_vld = issue_psrc1_vld | s1_vld[i];
        issue_psrc2_vld = issue_psrc2_vld | s2_vld[i];
        issue_pdst_vld  = issue_pdst_vld | pd_vld[i];
        issue_payload   = issue_payload | pld[i];
      end
    end
  end

  // Handshakes; flush suppresses both fires
  always_comb begin
`ifdef IDU_IS_IQ_FULL_BYPASS_EN
    create_rdy = (cnt != FULL_CNT) | (issue_vld & issue_rdy);
`else
    create_rdy = (cnt != FULL_CNT);
`endif
    iss_fire = issue_vld & issue_rdy & ~rtu_global_flush;
    cr_fire  = create_vld & create_rdy & ~rtu_global_flush;
  end

  // Lowest-index free slot; when full (bypass build) reuse the issuing slot
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_vld[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
`ifdef IDU_IS_IQ_FULL_BYPASS_EN
    if (!alloc_found) alloc_oh = sel_oh & {DEPTH{issue_vld & issue_rdy}};
`endif
  end

  // Entry storage, wakeup, free, create and age-matrix update
  always_ff @(posedge clk) begin
    if (!rst_clk || rtu_global_flush) begin
      ent_vld <= '0;
      s1_vld  <= '0;
      s1_rdy  <= '0;
      s2_vld  <= '0;
      s2_rdy  <= '0;
      pd_vld  <= '0;
      cnt     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        s1_tag[i] <= '0;
        s2_tag[i] <= '0;
        pd_tag[i] <= '0;
        pld[i]    <= '0;
        older[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && s1_vld[i] && w1_hit[i]) s1_rdy[i] <= 1'b1;
        if (ent_vld[i] && s2_vld[i] && w2_hit[i]) s2_rdy[i] <= 1'b1;
        if (iss_fire && sel_oh[i]) begin
          ent_vld[i] <= 1'b0;
          s1_vld[i]  <= 1'b0;
          s1_rdy[i]  <= 1'b0;
          s2_vld[i]  <= 1'b0;
          s2_rdy[i]  <= 1'b0;
          pd_vld[i]  <= 1'b0;
          s1_tag[i]  <= '0;
          s2_tag[i]  <= '0;
          pd_tag[i]  <= '0;
          pld[i]     <= '0;
        end
        if (cr_fire && alloc_oh[i]) begin
          ent_vld[i] <= 1'b1;
          s1_vld[i]  <= create_psrc1_vld;
          s1_rdy[i]  <= create_psrc1_ready | cr1_hit;
          s2_vld[i]  <= create_psrc2_vld;
          s2_rdy[i]  <= create_psrc2_ready | cr2_hit;
          pd_vld[i]  <= create_pdst_vld;
          s1_tag[i]  <= create_psrc1;
          s2_tag[i]  <= create_psrc2;
          pd_tag[i]  <= create_pdst_vld ? create_pdst : '0;
          pld[i]     <= create_payload;
        end
        for (int j = 0; j < DEPTH; j++) begin
          if (iss_fire && (sel_oh[i] || sel_oh[j])) older[i][j] <= 1'b0;
          if (cr_fire && alloc_oh[i]) older[i][j] <= 1'b0;
          if (cr_fire && alloc_oh[j] && (i != j))
            older[i][j] <= ent_vld[i] & ~(iss_fire & sel_oh[i]);
        end
      end
      cnt <= cnt + {{(CNT_W-1){1'b0}}, cr_fire} - {{(CNT_W-1){1'b0}}, iss_fire};
    end
  end

  assign entry_cnt = cnt;

endmodule
